median_window_filter: RTL and testbench

//  Streaming sliding-window median filter; parametrised successor of the 3-input combinational median.

---
 rtl/median_window_filter.sv | 115 +++++++++++
 tb/tb_median_window_filter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_filter.sv
// Sliding-window median filter: keeps the last WIN samples and sorts them by odd-even transposition, one pass per cycle.
// Optional MEDIAN_PRIME_EN: the first sample after rst/clr fills every window slot so medians start at once.
module median_window_filter #(
  parameter int DW  = 8,
  parameter int WIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          win_full
);
  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_C = CW'(WIN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  if ((WIN < 3) || (WIN > 15) || ((WIN % 2) == 0)) begin : g_bad_win
    $error("median_window_filter: WIN must be odd and within 3..15");
  end

  logic [1:0]             state;
  logic [CW-1:0]          fill;
  logic [CW-1:0]          fill_nxt;
  logic [CW-1:0]          pass;
  logic [WIN-1:0][DW-1:0] win_q;
  logic [WIN-1:0][DW-1:0] win_nxt;
  logic [WIN-1:0][DW-1:0] srt_q;
  logic [WIN-1:0][DW-1:0] srt_nxt;
  logic                   accept;

  assign in_ready = (state == IDLE) && !rst && !clr;
  assign accept   = in_valid && in_ready;
  assign win_full = (fill == WIN_C);

  // Slot 0 holds the newest sample; the top slot (oldest) falls off on each accept.
  always_comb begin
    win_nxt  = {win_q[WIN-2:0], in_data};
    fill_nxt = (fill == WIN_C) ? fill : fill + 1'b1;
`ifdef MEDIAN_PRIME_EN
    if (fill == '0) begin
      win_nxt  = {WIN{in_data}};
      fill_nxt = WIN_C;
    end
`endif
  end

  // Pairs within one pass never overlap, so every exchange reads the registered array.
  always_comb begin
    srt_nxt = srt_q;
    for (int i = 0; i < WIN - 1; i++) begin
      if ((i[0] == pass[0]) && (srt_q[i] > srt_q[i+1])) begin
        srt_nxt[i]   = srt_q[i+1];
        srt_nxt[i+1] = srt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill      <= '0;
      pass      <= '0;
      win_q     <= '0;
      srt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= IDLE;
      fill      <= '0;
      win_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            win_q <= win_nxt;
            fill  <= fill_nxt;
            if (fill_nxt == WIN_C) begin
              srt_q <= win_nxt;
              pass  <= '0;
              state <= SORT;
            end
          end
        end
        SORT: begin
          // WIN passes fully sort WIN values; the extra cycle registers the median.
          if (pass == WIN_C) begin
            out_data  <= srt_q[(WIN-1)/2];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            srt_q <= srt_nxt;
            pass  <= pass + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_filter.sv
// Bench for median_window_filter: directed cases then random samples, checked against a queue-and-sort window model.
module tb_median_window_filter;
  logic       clk = 1'b0;
  logic       rst;
  logic       clr_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, win_full_a;
  logic [7:0] in_data_a, out_data_a;
  logic       clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, win_full_b;
  logic [7:0] in_data_b, out_data_b;

  int vectors = 0;
  int miscompares = 0;

`ifdef MEDIAN_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  median_window_filter #(.DW(8), .WIN(3)) u_a (
    .clk(clk), .rst(rst), .clr(clr_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .win_full(win_full_a));

  median_window_filter #(.DW(8), .WIN(5)) u_b (
    .clk(clk), .rst(rst), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .win_full(win_full_b));

  always #5 clk = ~clk;

  // Reference model: index 0 -> WIN=3 instance, index 1 -> WIN=5 instance.
  int mq[2][$];
  int mfill[2];
  int mwin[2] = '{3, 5};
  int got_b[$];
  int exp_b[$];

  always @(negedge clk) begin
    if (out_valid_b && out_ready_b) got_b.push_back(int'(out_data_b));
  end

  function automatic void model_clear(input int id);
    mq[id].delete();
    mfill[id] = 0;
  endfunction

  // Returns the median the filter must emit for this sample, or -1 when none is due.
  function automatic int model_accept(input int id, input int d);
    int s[$];
    if (PRIME && mfill[id] == 0) begin
      for (int i = 0; i < mwin[id]; i++) mq[id].push_back(d);
      mfill[id] = mwin[id];
    end else begin
      mq[id].push_back(d);
      if (mq[id].size() > mwin[id]) void'(mq[id].pop_front());
      if (mfill[id] < mwin[id]) mfill[id]++;
    end
    if (mfill[id] < mwin[id]) return -1;
    s = mq[id];
    s.sort();
    return s[mwin[id] / 2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    clr_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    @(negedge clk);
    check("in_ready_in_rst", in_ready_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_data", out_data_a, 8'd0);
    check("rst_win_full", win_full_a, 1'b0);
    model_clear(0);
    model_clear(1);
  endtask

  // Offer one sample to the WIN=3 instance; hold>0 keeps out_ready low that many cycles after out_valid.
  task automatic send_a(input int d, input int hold);
    int med;
    int lat;
    out_ready_a = (hold == 0);
    in_valid_a = 1'b1;
    in_data_a = d[7:0];
    lat = 0;
    while (!in_ready_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_idle", in_ready_a, 1'b1);
    @(negedge clk);
    in_valid_a = 1'b0;
    med = model_accept(0, d);
    if (med < 0) begin
      repeat (6) begin
        check("no_out_filling", out_valid_a, 1'b0);
        @(negedge clk);
      end
      check("win_full_filling", win_full_a, 1'b0);
      out_ready_a = 1'b1;
    end else begin
      check("in_ready_busy", in_ready_a, 1'b0);
      lat = 0;
      while (!out_valid_a && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      check("latency", lat, 4);
      check("median", out_data_a, med);
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", out_valid_a, 1'b1);
        check("hold_data", out_data_a, med);
        check("hold_in_ready", in_ready_a, 1'b0);
      end
      out_ready_a = 1'b1;
      @(negedge clk);
      check("handshake_done", out_valid_a, 1'b0);
      check("win_full_after", win_full_a, 1'b1);
    end
  endtask

  task automatic do_clr_a();
    clr_a = 1'b1;
    in_valid_a = 1'b1;
    in_data_a = 8'hAA;
    #1;
    check("clr_in_ready", in_ready_a, 1'b0);
    @(negedge clk);
    clr_a = 1'b0;
    in_valid_a = 1'b0;
    #1;
    check("clr_win_full", win_full_a, 1'b0);
    check("clr_out_valid", out_valid_a, 1'b0);
    model_clear(0);
  endtask

  task automatic send_b(input int d);
    int n;
    int med;
    in_valid_b = 1'b1;
    in_data_b = d[7:0];
    n = 0;
    while (!in_ready_b && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b_in_ready", in_ready_b, 1'b1);
    @(negedge clk);
    in_valid_b = 1'b0;
    med = model_accept(1, d);
    if (med >= 0) exp_b.push_back(med);
  endtask

  task automatic compare_b(input string tag);
    repeat (12) @(negedge clk);
    check({tag, "_count"}, got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check({tag, "_median"}, got_b[i], exp_b[i]);
    check({tag, "_win_full"}, win_full_b, (mfill[1] == 5));
  endtask

  initial begin
    do_reset();

    // Fill, slide, then a held output.
    send_a(1, 0); send_a(2, 0); send_a(3, 0);
    send_a(4, 0); send_a(0, 0);
    send_a(255, 0); send_a(128, 0); send_a(0, 10);

    // Reset in the middle of a sort discards the pending median.
    do_reset();
    send_a(7, 0); send_a(7, 0);
    in_valid_a = 1'b1;
    in_data_a = 8'd7;
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready_a, 1'b0);
    rst = 1'b0;
    model_clear(0);
    model_clear(1);
    repeat (6) begin
      #1;
      check("abort_no_out", out_valid_a, 1'b0);
      @(negedge clk);
    end
    check("abort_win_full", win_full_a, 1'b0);
    send_a(5, 0); send_a(1, 0); send_a(3, 0);

    // Five-deep window, then clear.
    send_b(9); send_b(2); send_b(9); send_b(2); send_b(5);
    compare_b("win5");
    clr_b = 1'b1;
    in_valid_b = 1'b1;
    #1;
    check("b_clr_in_ready", in_ready_b, 1'b0);
    @(negedge clk);
    clr_b = 1'b0;
    in_valid_b = 1'b0;
    model_clear(1);
    send_b(4);
    compare_b("win5_clr");

    // First samples after reset.
    do_reset();
    send_a(9, 0); send_a(1, 0); send_a(1, 0);

    // Random samples with ties, back-pressure and occasional clears.
    for (int i = 0; i < 60; i++) begin
      int d;
      int hold;
      d = (i % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      if ($urandom_range(0, 9) == 0) do_clr_a();
      send_a(d, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
